// File: rtl/n64_bus_pkg.sv
// Shared definitions for the N64 bus router: bank codes, open-bus value
// and the router state encoding.
package n64_bus_pkg;

  localparam int BANK_W = 4;
  localparam int ADDR_W = 26;
  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] OPEN_BUS = 32'hFFFF_FFFF;

  typedef enum logic [BANK_W-1:0] {
    BANK_RDRAM      = 4'd0,
    BANK_RDRAM_REGS = 4'd1,
    BANK_SP         = 4'd2,
    BANK_DP         = 4'd3,
    BANK_MI         = 4'd4,
    BANK_VI         = 4'd5,
    BANK_AI         = 4'd6,
    BANK_PI         = 4'd7,
    BANK_INVALID    = 4'hF
  } bank_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_e;

  function automatic logic bank_valid(input logic [BANK_W-1:0] bank, input int num_banks);
    return int'(bank) < num_banks;
  endfunction

endpackage

// File: rtl/n64_bus_watchdog.sv
// Transaction watchdog for the bus router; only instantiated when
// N64_BUS_TIMEOUT_EN is defined.
module n64_bus_watchdog #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic active_i,
  output logic expired_o
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (start_i)       count_d = '0;
    else if (active_i) count_d = count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  // Flag the cycle whose increment would reach LIMIT so the router leaves
  // on exactly that edge.
  assign expired_o = active_i && ((count_q + 8'd1) == LIMIT);

endmodule

// File: rtl/n64_bus_router.sv
// Routes one PI-stage request at a time to a one-hot selected device bank.
// Optional watchdog enabled by defining N64_BUS_TIMEOUT_EN.
module n64_bus_router
  import n64_bus_pkg::*;
#(
  parameter int NUM_BANKS      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_request,
  input  logic                    i_write,
  input  logic [BANK_W-1:0]       i_bank,
  input  logic [ADDR_W-1:0]       i_address,
  input  logic [DATA_W-1:0]       i_data,
  output logic                    o_busy,
  output logic                    o_ack,
  output logic [DATA_W-1:0]       o_data,
  output logic [NUM_BANKS-1:0]    o_dev_request,
  output logic                    o_dev_write,
  output logic [ADDR_W-1:0]       o_dev_address,
  output logic [DATA_W-1:0]       o_dev_data,
  input  logic [NUM_BANKS-1:0]    i_dev_busy,
  input  logic [NUM_BANKS-1:0]    i_dev_ack,
  input  logic [NUM_BANKS*32-1:0] i_dev_data,
  output logic                    o_timeout
);

  state_e              state_q, state_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                timeout_q, timeout_d;

  logic [NUM_BANKS-1:0] dev_sel;
  logic                 sel_busy, sel_ack;
  logic [DATA_W-1:0]    sel_data;
  logic                 wd_start, wd_expired;

  always_comb begin
    dev_sel  = '0;
    sel_busy = 1'b0;
    sel_ack  = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      dev_sel[i] = (bank_q == BANK_W'(i));
      sel_busy   = sel_busy | (dev_sel[i] & i_dev_busy[i]);
      sel_ack    = sel_ack  | (dev_sel[i] & i_dev_ack[i]);
      sel_data   = sel_data | (i_dev_data[i*32 +: 32] & {DATA_W{dev_sel[i]}});
    end
  end

  assign wd_start = (state_q == ST_IDLE) && i_request && bank_valid(i_bank, NUM_BANKS);

`ifdef N64_BUS_TIMEOUT_EN
  n64_bus_watchdog #(
    .LIMIT (8'(TIMEOUT_CYCLES))
  ) u_watchdog (
    .clk       (i_clk),
    .rst_n     (i_reset_n),
    .start_i   (wd_start),
    .active_i  (state_q != ST_IDLE),
    .expired_o (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  // NOTE: every _d gets a default first so no branch can infer a latch.
  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ack_d     = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_request) begin
          bank_d  = i_bank;
          write_d = i_write;
          addr_d  = i_address;
          wdata_d = i_data;
          if (bank_valid(i_bank, NUM_BANKS)) begin
            state_d = ST_ISSUE;
          end else if (!i_write) begin
            ack_d   = 1'b1;
            rdata_d = OPEN_BUS;
          end
        end
      end
      ST_ISSUE: begin
        if (wd_expired) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
          ack_d     = !write_q;
          if (!write_q) rdata_d = OPEN_BUS;
        end else if (!sel_busy) begin
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // A genuine device ack wins over a watchdog expiry in the same cycle.
        if (sel_ack) begin
          state_d = ST_IDLE;
          ack_d   = !write_q;
          if (!write_q) rdata_d = sel_data;
        end else if (wd_expired) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
          ack_d     = !write_q;
          if (!write_q) rdata_d = OPEN_BUS;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      bank_q    <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_busy        = (state_q != ST_IDLE);
  assign o_ack         = ack_q;
  assign o_data        = rdata_q;
  assign o_dev_request = (state_q == ST_ISSUE) ? dev_sel : '0;
  assign o_dev_write   = write_q;
  assign o_dev_address = addr_q;
  assign o_dev_data    = wdata_q;
  assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_n64_bus_router.sv
// Directed self-checking bench for n64_bus_router; covers the watchdog
// path when N64_BUS_TIMEOUT_EN is defined.
module tb_n64_bus_router;

  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          request, write;
  logic [3:0]    bank;
  logic [25:0]   address;
  logic [31:0]   data;
  logic          busy, ack, timeout;
  logic [31:0]   rdata;
  logic [NB-1:0] dev_request;
  logic          dev_write;
  logic [25:0]   dev_address;
  logic [31:0]   dev_data_o;
  logic [NB-1:0] dev_busy, dev_ack;
  logic [NB*32-1:0] dev_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  n64_bus_router #(
    .NUM_BANKS      (NB),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_request     (request),
    .i_write       (write),
    .i_bank        (bank),
    .i_address     (address),
    .i_data        (data),
    .o_busy        (busy),
    .o_ack         (ack),
    .o_data        (rdata),
    .o_dev_request (dev_request),
    .o_dev_write   (dev_write),
    .o_dev_address (dev_address),
    .o_dev_data    (dev_data_o),
    .i_dev_busy    (dev_busy),
    .i_dev_ack     (dev_ack),
    .i_dev_data    (dev_data),
    .o_timeout     (timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic wr, input logic [3:0] bk, input logic [25:0] ad, input logic [31:0] dt);
    request = 1'b1;
    write   = wr;
    bank    = bk;
    address = ad;
    data    = dt;
    step(1);
    request = 1'b0;
  endtask

  int  held;
  int  saw_ack;
  int  unstable;
  int  t_at;
  logic [31:0] t_ack, t_data;

  initial begin
    reset_n  = 1'b0;
    request  = 1'b0;
    write    = 1'b0;
    bank     = '0;
    address  = '0;
    data     = '0;
    dev_busy = '0;
    dev_ack  = '0;
    dev_data = '0;
    step(2);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_data", rdata, 0);
    check("rst_devreq", dev_request, 0);
    check("rst_timeout", timeout, 0);
    check("rst_devaddr", dev_address, 0);
    reset_n = 1'b1;
    step(1);

    // Read bank 0, device acks three cycles after the request cycle.
    issue(1'b0, 4'd0, 26'h012_3456, 32'h0);
    check("rd0_busy", busy, 1);
    check("rd0_req", dev_request, 8'h01);
    check("rd0_addr", dev_address, 26'h012_3456);
    step(1);
    check("rd0_req_drop", dev_request, 0);
    check("rd0_wait_busy", busy, 1);
    step(1);
    dev_ack[0] = 1'b1;
    dev_data[31:0] = 32'h1234_5678;
    step(1);
    dev_ack = '0;
    check("rd0_ack", ack, 1);
    check("rd0_data", rdata, 32'h1234_5678);
    check("rd0_idle", busy, 0);
    step(1);
    check("rd0_ack_pulse", ack, 0);
    check("rd0_data_hold", rdata, 32'h1234_5678);

    // Write bank 2 while the device stays busy for four ISSUE cycles.
    dev_busy[2] = 1'b1;
    issue(1'b1, 4'd2, 26'h2AB_CDEF, 32'hDEAD_BEEF);
    held = 0; saw_ack = 0; unstable = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 5) dev_busy[2] = 1'b0;
      if (dev_request == 8'h04) held++;
      if (ack) saw_ack++;
      if (dev_address != 26'h2AB_CDEF || dev_data_o != 32'hDEAD_BEEF || !dev_write) unstable++;
      step(1);
    end
    check("wr2_held", held, 5);
    check("wr2_stable", unstable, 0);
    dev_ack[2] = 1'b1;
    step(1);
    dev_ack = '0;
    if (ack) saw_ack++;
    check("wr2_no_ack", saw_ack, 0);
    check("wr2_idle", busy, 0);

    // Invalid banks: read 15 returns open bus, write 8 is dropped.
    issue(1'b0, 4'd15, 26'h0, 32'h0);
    check("inv_rd_ack", ack, 1);
    check("inv_rd_data", rdata, 32'hFFFF_FFFF);
    check("inv_rd_req", dev_request, 0);
    check("inv_rd_busy", busy, 0);
    issue(1'b1, 4'd8, 26'h1, 32'h5);
    check("inv_wr_ack", ack, 0);
    check("inv_wr_busy", busy, 0);
    check("inv_wr_req", dev_request, 0);

    // Stray acks: during ISSUE and from another bank must be ignored.
    issue(1'b0, 4'd0, 26'h000_0040, 32'h0);
    dev_ack = 8'h01;
    step(1);
    check("stray_issue_ack", ack, 0);
    check("stray_issue_busy", busy, 1);
    dev_ack = 8'h02;
    dev_data[63:32] = 32'hAAAA_5555;
    step(1);
    check("stray_b1_ack", ack, 0);
    check("stray_b1_busy", busy, 1);
    dev_ack = 8'h01;
    dev_data[31:0] = 32'hCAFE_F00D;
    step(1);
    dev_ack = '0;
    check("stray_done_ack", ack, 1);
    check("stray_done_data", rdata, 32'hCAFE_F00D);

    // Highest valid bank exercises the top of the data mux.
    issue(1'b0, 4'd7, 26'h3FF_FFFF, 32'h0);
    check("rd7_req", dev_request, 8'h80);
    step(1);
    dev_ack[7] = 1'b1;
    dev_data[255:224] = 32'h7654_3210;
    step(1);
    dev_ack = '0;
    check("rd7_data", rdata, 32'h7654_3210);

    // Reset during WAIT_ACK abandons the transaction.
    issue(1'b0, 4'd3, 26'h000_1000, 32'h0);
    step(1);
    check("rst_mid_wait", busy, 1);
    reset_n = 1'b0;
    #2;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_data", rdata, 0);
    check("rst_mid_req", dev_request, 0);
    #1;
    reset_n = 1'b1;
    dev_ack[3] = 1'b1;
    dev_data[127:96] = 32'h3333_3333;
    step(1);
    dev_ack = '0;
    check("rst_after_ack", ack, 0);
    check("rst_after_data", rdata, 0);
    check("rst_after_busy", busy, 0);

`ifdef N64_BUS_TIMEOUT_EN
    // Read never acked: watchdog fires 16 cycles after ISSUE entry.
    issue(1'b0, 4'd1, 26'h000_0200, 32'h0);
    t_at = 0; t_ack = 0; t_data = 0;
    for (int k = 1; k <= 24; k++) begin
      step(1);
      if (timeout && t_at == 0) begin
        t_at   = k;
        t_ack  = 32'(ack);
        t_data = rdata;
      end
    end
    check("to_cycle", t_at, 16);
    check("to_ack", t_ack, 1);
    check("to_data", t_data, 32'hFFFF_FFFF);
    check("to_idle", busy, 0);
`else
    // Without the watchdog a silent device keeps the router waiting.
    issue(1'b0, 4'd1, 26'h000_0200, 32'h0);
    t_at = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (timeout || !busy) t_at++;
    end
    check("nowd_wait", t_at, 0);
    dev_ack[1] = 1'b1;
    dev_data[63:32] = 32'h1111_2222;
    step(1);
    dev_ack = '0;
    check("nowd_done_data", rdata, 32'h1111_2222);
    check("nowd_timeout", timeout, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/n64_bus_router.md
N64_BUS_ROUTER -- requirements
Module: n64_bus_router

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 8, number of downstream device ports (bank codes 0..NUM_BANKS-1).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, watchdog limit in i_clk cycles (8-bit, 1..255).
REQ-003 SHALL have port i_clk  input  1  the single clock for all logic.
REQ-004 SHALL have port i_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have upstream ports i_request/i_write (1 each), i_bank (4), i_address (26), i_data (32): request from the PI stage.
REQ-006 SHALL have upstream outputs o_busy (1), o_ack (1), o_data (32): busy, read-acknowledge and read data back to the PI stage.
REQ-007 SHALL have downstream outputs o_dev_request (NUM_BANKS, one-hot), o_dev_write (1), o_dev_address (26), o_dev_data (32).
REQ-008 SHALL have downstream inputs i_dev_busy (NUM_BANKS), i_dev_ack (NUM_BANKS), i_dev_data (NUM_BANKS*32, bank n at bits [32n+31:32n]).
REQ-009 SHALL have output o_timeout (1): single-cycle pulse on watchdog expiry.

Function
REQ-010 SHALL implement states IDLE, ISSUE, WAIT_ACK; o_busy SHALL equal (state != IDLE).
REQ-011 SHALL accept a request when i_request && !o_busy, latching bank, write, address and data in that cycle.
REQ-012 On acceptance of a valid bank (< NUM_BANKS) SHALL enter ISSUE; o_dev_request[bank] SHALL be high from the next cycle.
REQ-013 On acceptance of an invalid bank (>= NUM_BANKS, including BANK_INVALID) SHALL stay IDLE; a read SHALL produce o_ack=1, o_data=32'hFFFF_FFFF one cycle later; a write SHALL be dropped silently.
REQ-014 In ISSUE, request SHALL hold until !i_dev_busy[bank]; in that cycle it SHALL deassert next cycle and state SHALL go to WAIT_ACK.
REQ-015 In WAIT_ACK, on i_dev_ack[bank] SHALL return to IDLE; for reads SHALL register o_ack=1 and o_data=bank data on the next cycle.
REQ-016 o_ack SHALL be a single-cycle pulse and SHALL never assert for writes.
REQ-017 o_data SHALL hold its last value between acks.
REQ-018 i_dev_ack from a non-selected bank, or any ack in IDLE or ISSUE, SHALL be ignored.
REQ-019 o_dev_write/address/data SHALL remain stable from ISSUE entry until return to IDLE.
REQ-020 At most one transaction SHALL be outstanding.

Reset
REQ-021 Asserting i_reset_n low SHALL immediately force state IDLE; all outputs 0, o_data 32'h0.
REQ-022 Reset mid-transaction SHALL abandon it; no ack SHALL be produced after release for the abandoned transaction.

Configuration
REQ-023 With N64_BUS_TIMEOUT_EN defined, an 8-bit counter SHALL clear on ISSUE entry and increment each ISSUE/WAIT_ACK cycle.
REQ-024 When it reaches TIMEOUT_CYCLES, SHALL drop o_dev_request, pulse o_timeout and return to IDLE; a read SHALL also return o_ack with 32'hFFFF_FFFF.
REQ-025 Without N64_BUS_TIMEOUT_EN, SHALL wait indefinitely; o_timeout SHALL be tied 0 and no counter SHALL exist.

Structure
REQ-026 Bank codes, BANK_INVALID, the open-bus value 32'hFFFF_FFFF and the state encoding SHALL live in shared package n64_bus_pkg.
REQ-027 The watchdog SHALL be sub-module n64_bus_watchdog, instantiated only under N64_BUS_TIMEOUT_EN.

Verification
REQ-028 Read bank 0, i_dev_busy[0] low, ack 3 cycles later with 32'h1234_5678 -> o_ack one cycle after ack, o_data=32'h1234_5678, o_busy low the same cycle.
REQ-029 Write bank 2 with i_dev_busy[2] high 4 cycles -> o_dev_request[2] held 5 cycles, address/data stable, no o_ack.
REQ-030 Read bank 15 (invalid) -> no o_dev_request, o_ack next cycle with 32'hFFFF_FFFF.
REQ-031 Stray i_dev_ack[1] while waiting on bank 0 -> ignored; completion only on i_dev_ack[0].
REQ-032 Reset pulse during WAIT_ACK, then device ack -> outputs zero, no o_ack.
REQ-033 With N64_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16, read never acked -> o_timeout and o_ack with 32'hFFFF_FFFF 16 cycles after ISSUE entry.
